// File: rtl/rtm_shift_datapath.sv
// rtm_shift_datapath
// Racetrack-memory word datapath. Every bank remembers which domain position
// sits under its access port. An accepted request first aligns the target bank
// by shifting the shortest way round the track, then performs one access cycle.
// The result is a read word or a byte-masked write.
// Completion is a registered one-cycle rvalid_o pulse, so latency grows with
// the shift distance.

module rtm_shift_datapath #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int NBANK        = 4,
  parameter int NSP          = 4,
  parameter int SHIFT_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic                     we_i,
  input  logic [DATA_WIDTH/8-1:0]  be_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic                     rvalid_o,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     shift_en_o,
  output logic                     shift_dir_o,
  output logic [$clog2(NBANK)-1:0] shift_bank_o,
  output logic [31:0]              shift_total_o
);

  localparam int WIDX_W  = ADDR_WIDTH - 2;
  localparam int NBYTES  = DATA_WIDTH / 8;
  localparam int BANK_W  = $clog2(NBANK);
  localparam int POS_W   = $clog2(NSP);
  localparam int MEM_AW  = $clog2(DEPTH_WORDS);
  localparam int CYC_W   = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Storage. It is never cleared, so contents survive reset.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Control state
  state_t                w_state_next;
  state_t                r_state;
  logic [POS_W-1:0]      r_pos [NBANK];

  // Captured request
  logic                  r_we;
  logic [NBYTES-1:0]     r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MEM_AW-1:0]     r_idx;
  logic                  r_oor;
  logic [BANK_W-1:0]     r_bank;
  logic [POS_W-1:0]      r_tgt;
  logic                  r_dir;

  // Shift sequencing
  logic [POS_W-1:0]      r_steps;
  logic [CYC_W-1:0]      r_cyc;
  logic [31:0]           r_total;

  // Response
  logic                  r_rvalid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  // Request decode and shift planning
  logic [WIDX_W-1:0]     w_w;
  logic [BANK_W-1:0]     w_bank;
  logic [POS_W-1:0]      w_pos;
  logic [POS_W-1:0]      w_cur;
  logic [POS_W-1:0]      w_d;
  logic                  w_fwd;
  logic                  w_oor;
  logic [POS_W-1:0]      w_steps;
  logic                  w_accept;
  logic                  w_step_end;
  logic                  w_last_step;
  logic                  w_mem_we;

  // Word index drops the byte offset. Bank and position use the low bits
  // because NBANK and NSP are powers of two.
  assign w_w    = WIDX_W'(addr_i >> 2);
  assign w_bank = BANK_W'(w_w);
  assign w_pos  = POS_W'(w_w >> BANK_W);
  assign w_oor  = (32'(w_w) >= 32'(DEPTH_WORDS));
  assign w_cur  = r_pos[w_bank];

  // Forward distance wraps naturally in POS_W bits. A tie at NSP/2 goes forward.
  // Backward distance is the two's-complement of the forward distance.
  assign w_d     = w_pos - w_cur;
  assign w_fwd   = ({1'b0, w_d} <= (POS_W + 1)'(NSP / 2));
  assign w_steps = w_oor ? '0 : (w_fwd ? w_d : (POS_W'(0) - w_d));

  assign w_accept    = req_i && (r_state == ST_IDLE);
  assign w_step_end  = (r_state == ST_SHIFT) && (r_cyc == CYC_W'(SHIFT_CYCLES - 1));
  assign w_last_step = w_step_end && (r_steps == POS_W'(1));

  // A reset landing on the access cycle must not commit the write.
  assign w_mem_we = (r_state == ST_ACCESS) && r_we && !r_oor && !rst_i;

  assign gnt_o         = (r_state == ST_IDLE);
  assign busy_o        = (r_state != ST_IDLE);
  assign shift_en_o    = (r_state == ST_SHIFT);
  assign shift_dir_o   = (r_state == ST_SHIFT) && r_dir;
  assign shift_bank_o  = r_bank;
  assign shift_total_o = r_total;
  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign err_o         = r_err;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: skip SHIFT when already aligned or out of range
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = (w_steps != '0) ? ST_SHIFT : ST_ACCESS;
        end
      end
      ST_SHIFT: begin
        if (w_last_step) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the request and its shift plan on the accept edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_oor   <= 1'b0;
      r_bank  <= '0;
      r_tgt   <= '0;
      r_dir   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= we_i;
      r_be    <= be_i;
      r_wdata <= wdata_i;
      r_idx   <= MEM_AW'(w_w);
      r_oor   <= w_oor;
      r_bank  <= w_bank;
      r_tgt   <= w_pos;
      r_dir   <= w_fwd;
    end
  end

  // Step and cycle-within-step counters for the SHIFT phase
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_steps <= '0;
      r_cyc   <= '0;
    end else if (w_accept) begin
      r_steps <= w_steps;
      r_cyc   <= '0;
    end else if (r_state == ST_SHIFT) begin
      if (w_step_end) begin
        r_steps <= r_steps - POS_W'(1);
        r_cyc   <= '0;
      end else begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
    end
  end

  // Per-bank port position: only the shifted bank moves, and only once all steps are done
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBANK; b++) begin
        r_pos[b] <= '0;
      end
    end else if (w_last_step) begin
      r_pos[r_bank] <= r_tgt;
    end
  end

  // Saturating count of completed single-position shifts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_total <= '0;
    end else if (w_step_end && (r_total != 32'hFFFF_FFFF)) begin
      r_total <= r_total + 32'd1;
    end
  end

  // Byte-masked write into the word array
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int bi = 0; bi < NBYTES; bi++) begin
        if (r_be[bi]) begin
          r_mem[r_idx][bi*8 +: 8] <= r_wdata[bi*8 +: 8];
        end
      end
    end
  end

  // Registered completion. Read data is latched in ACCESS and held until the next pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= (r_state == ST_ACCESS);
      if (r_state == ST_ACCESS) begin
        r_err   <= r_oor;
        r_rdata <= (r_we || r_oor) ? '0 : r_mem[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_rtm_shift_datapath.sv
// Directed bench for rtm_shift_datapath.
// The bench uses an 11-bit address so that out-of-range words can be reached.
module tb_rtm_shift_datapath;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int SC = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic          gnt_o;
  logic          we_i;
  logic [3:0]    be_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          busy_o;
  logic          shift_en_o;
  logic          shift_dir_o;
  logic [1:0]    shift_bank_o;
  logic [31:0]   shift_total_o;

  int n_checks = 0;
  int n_errors = 0;

  rtm_shift_datapath #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(256),
    .NBANK(4), .NSP(4), .SHIFT_CYCLES(SC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .shift_en_o(shift_en_o), .shift_dir_o(shift_dir_o),
    .shift_bank_o(shift_bank_o), .shift_total_o(shift_total_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction. Inputs are driven on the falling edge and accepted on the next rising edge.
  // Outputs are sampled on the falling edges that follow.
  // Cycle c is the c-th sample after the accept edge.
  task automatic run(input string tag, input logic we, input logic [3:0] be,
                     input logic [AW-1:0] addr, input logic [31:0] wd,
                     input int exp_lat, input int exp_steps, input logic exp_dir,
                     input logic [1:0] exp_bank, input logic do_rd,
                     input logic [31:0] exp_rd, input logic exp_err);
    int c;
    int nsh;
    logic seen;
    logic dir0;
    logic held_ok;
    logic [31:0] rd;
    logic er;
    c = 0; nsh = 0; seen = 1'b0; dir0 = 1'b0; held_ok = 1'b1; rd = '0; er = 1'b0;
    @(negedge clk_i);
    chk({tag, ".gnt"}, 64'(gnt_o), 64'(1));
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    while (!seen && c < 40) begin
      @(negedge clk_i);
      req_i = 1'b0;
      c++;
      if (shift_en_o) begin
        if (nsh == 0) dir0 = shift_dir_o;
        else if (shift_dir_o !== dir0) held_ok = 1'b0;
        if (shift_bank_o !== exp_bank) held_ok = 1'b0;
        nsh++;
      end
      if (rvalid_o) begin
        seen = 1'b1;
        rd   = rdata_o;
        er   = err_o;
      end
    end
    chk({tag, ".lat"}, seen ? 64'(c) : 64'(0), 64'(exp_lat));
    chk({tag, ".shift_cycles"}, 64'(nsh), 64'(exp_steps * SC));
    if (exp_steps > 0) begin
      chk({tag, ".dir"}, 64'(dir0), 64'(exp_dir));
      chk({tag, ".dir_bank_held"}, 64'(held_ok), 64'(1));
    end
    chk({tag, ".err"}, 64'(er), 64'(exp_err));
    if (do_rd) chk({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
    $display("txn %s we=%0d be=%h addr=0x%03h lat=%0d shift_cycles=%0d rdata=0x%08h err=%0d total=%0d",
             tag, we, be, addr, c, nsh, rd, er, shift_total_o);
  endtask

  initial begin
    int rv;
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.gnt", 64'(gnt_o), 64'(1));
    chk("rst.busy", 64'(busy_o), 64'(0));
    chk("rst.rvalid", 64'(rvalid_o), 64'(0));
    chk("rst.err", 64'(err_o), 64'(0));
    chk("rst.shift_en", 64'(shift_en_o), 64'(0));
    chk("rst.shift_dir", 64'(shift_dir_o), 64'(0));
    chk("rst.shift_bank", 64'(shift_bank_o), 64'(0));
    chk("rst.rdata", 64'(rdata_o), 64'(0));
    chk("rst.total", 64'(shift_total_o), 64'(0));
    rst_i = 1'b0;

    // Aligned accesses on bank0 at position 0
    run("wr0_pre",   1, 4'hF, 11'h000, 32'h0000_0000, 2, 0, 0, 2'd0, 1, 32'h0, 0);
    run("rd0",       0, 4'hF, 11'h000, 32'h0,         2, 0, 0, 2'd0, 1, 32'h0, 0);
    // w8 is bank0 pos2: a distance-2 tie goes forward
    run("wr020",     1, 4'hF, 11'h020, 32'hDEAD_BEEF, 6, 2, 1, 2'd0, 1, 32'h0, 0);
    run("rd020",     0, 4'hF, 11'h020, 32'h0,         2, 0, 0, 2'd0, 1, 32'hDEAD_BEEF, 0);
    chk("total_after_wr020", 64'(shift_total_o), 64'(2));
    // Return bank0 from pos2 to pos0: another tie, so forward 2
    run("rd000_tie", 0, 4'hF, 11'h000, 32'h0,         6, 2, 1, 2'd0, 1, 32'h0, 0);
    // w12 is pos3: a forward distance of 3 becomes one backward step
    run("rd030",     0, 4'hF, 11'h030, 32'h0,         4, 1, 0, 2'd0, 0, 32'h0, 0);
    run("rd000_fwd", 0, 4'hF, 11'h000, 32'h0,         4, 1, 1, 2'd0, 1, 32'h0, 0);
    chk("total_after_pos_walk", 64'(shift_total_o), 64'(6));

    // Byte masking on bank1 pos0 (w1)
    run("wr004",     1, 4'hF, 11'h004, 32'hAABB_CCDD, 2, 0, 0, 2'd1, 1, 32'h0, 0);
    run("wr004_be5", 1, 4'h5, 11'h004, 32'h1122_3344, 2, 0, 0, 2'd1, 1, 32'h0, 0);
    run("rd004_a",   0, 4'hF, 11'h004, 32'h0,         2, 0, 0, 2'd1, 1, 32'hAA22_CC44, 0);
    run("wr004_be0", 1, 4'h0, 11'h004, 32'hFFFF_FFFF, 2, 0, 0, 2'd1, 1, 32'h0, 0);
    run("rd004_b",   0, 4'hF, 11'h004, 32'h0,         2, 0, 0, 2'd1, 1, 32'hAA22_CC44, 0);
    repeat (3) @(negedge clk_i);
    chk("rdata_hold", 64'(rdata_o), 64'(32'hAA22_CC44));

    // w5 is bank1 pos1. Bank0 must stay at pos0.
    run("wr014",     1, 4'hF, 11'h014, 32'h0140_0140, 4, 1, 1, 2'd1, 1, 32'h0, 0);
    run("rd000_ind", 0, 4'hF, 11'h000, 32'h0,         2, 0, 0, 2'd0, 1, 32'h0, 0);
    chk("total_after_bank1", 64'(shift_total_o), 64'(7));

    // Out of range (w256 and w508): no shift, err, zero data, positions kept
    run("oor400",    0, 4'hF, 11'h400, 32'h0,         2, 0, 0, 2'd0, 1, 32'h0, 1);
    run("oor7f0",    1, 4'hF, 11'h7F0, 32'h1234_5678, 2, 0, 0, 2'd0, 1, 32'h0, 1);
    run("rd000_post",0, 4'hF, 11'h000, 32'h0,         2, 0, 0, 2'd0, 1, 32'h0, 0);
    chk("total_after_oor", 64'(shift_total_o), 64'(7));

    // Reset during the SHIFT of a write to w8
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 11'h020; wdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    req_i = 1'b0;
    chk("abort.in_shift", 64'(shift_en_o), 64'(1));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort.busy", 64'(busy_o), 64'(0));
    chk("abort.total", 64'(shift_total_o), 64'(0));
    rv = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (rvalid_o) rv++;
    end
    chk("abort.no_rvalid", 64'(rv), 64'(0));
    $display("txn abort_wr020 reset during shift, rvalid pulses=%0d", rv);
    // Bank1 is back at pos0, so w5 needs one forward step
    run("rd014_post", 0, 4'hF, 11'h014, 32'h0,        4, 1, 1, 2'd1, 1, 32'h0140_0140, 0);
    // Bank0 is back at pos0, and the aborted write left the word alone
    run("rd020_post", 0, 4'hF, 11'h020, 32'h0,        6, 2, 1, 2'd0, 1, 32'hDEAD_BEEF, 0);
    chk("total_after_abort", 64'(shift_total_o), 64'(3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtm_shift_datapath.md
Name: rtm_shift_datapath

Overview:
Parametrised racetrack-memory datapath with alignment-aware access. It holds a banked word array. Each bank tracks the domain position currently under its access ports. Every request is aligned with bidirectional shortest-path shifting, then a read or byte-masked write is performed, so latency depends on the shift distance. It sits between the core's data-port handshake and the racetrack storage and replaces the fixed-shift, single-cycle decode datapath.

Parameters:
ADDR_WIDTH, 10, byte address width
DATA_WIDTH, 32, word width, multiple of 8
DEPTH_WORDS, 256, number of words; 2**(ADDR_WIDTH-2) >= DEPTH_WORDS
NBANK, 4, independent racetracks/banks, power of 2
NSP, 4, domain positions per port (Nb/Np), power of 2, >= 2
SHIFT_CYCLES, 2, clock cycles per one-position shift, >= 1

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  request valid
gnt_o  out  1  request accepted when req_i & gnt_o
we_i  in  1  1 = write, 0 = read
be_i  in  DATA_WIDTH/8  byte enables, write only
addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
wdata_i  in  DATA_WIDTH  write data
rvalid_o  out  1  one-cycle completion pulse for reads and writes
rdata_o  out  DATA_WIDTH  read data, valid with rvalid_o
err_o  out  1  out-of-range flag, valid with rvalid_o
busy_o  out  1  state != IDLE
shift_en_o  out  1  high during every SHIFT cycle
shift_dir_o  out  1  1 = forward, 0 = backward; valid with shift_en_o
shift_bank_o  out  clog2(NBANK)  bank being shifted
shift_total_o  out  32  saturating count of completed one-position shifts

Behaviour:
- Reset: state IDLE; pos_q[b] = 0 for all banks; rvalid_o, err_o, shift_en_o, shift_dir_o, busy_o = 0; rdata_o = 0; shift_bank_o = 0; shift_total_o = 0. The array is not cleared.
- Reset mid-operation aborts the transaction with no array update and no rvalid_o, and returns all positions to 0.
- Address map: w = addr_i[ADDR_WIDTH-1:2]; bank = w mod NBANK; pos = (w / NBANK) mod NSP.
- gnt_o = (state == IDLE). The request (we, be, wdata, w, bank, pos) is captured on the accept edge.
- Shift planning at accept:
  - d = (pos - pos_q[bank]) mod NSP.
  - d = 0: no shift.
  - d <= NSP/2: forward d steps (a tie is forward).
  - Otherwise: backward NSP-d steps.
- Out-of-range request (w >= DEPTH_WORDS): no shift, no write, rdata_o = 0, err_o = 1 with rvalid_o.
- FSM IDLE -> SHIFT if steps > 0, else ACCESS.
- SHIFT:
  - Each step lasts SHIFT_CYCLES cycles with shift_en_o = 1 and shift_dir_o and shift_bank_o held.
  - At the end of each step, shift_total_o increments by 1, saturating at 2^32-1.
  - After the last step: pos_q[bank] = pos, go to ACCESS.
- ACCESS (1 cycle):
  - Read latches array[w] into rdata_o.
  - Write updates only the bytes with be_i set; be_i = 0 leaves the word unchanged but still acknowledges.
  - Next state IDLE.
- rvalid_o is registered: high exactly the cycle after ACCESS. That cycle is also IDLE, so gnt_o = 1 and back-to-back accepts are allowed.
- For writes, rdata_o = 0. rdata_o holds its value until the next rvalid_o.
- Latency from the accept edge with k steps: ACCESS in cycle 1 + k*SHIFT_CYCLES; rvalid_o in cycle 2 + k*SHIFT_CYCLES.
- Banks are independent: shifting one bank leaves every other pos_q unchanged.
- req_i while busy is not accepted; the requester holds it.

Test Plan:
- Reset, then read addr 0x000 → no shift; rvalid_o 2 cycles after accept; rdata_o = 0 (after preload write 0 check); pos_q[0] = 0.
- Write 0xDEADBEEF, be = 4'hF, to 0x020 (w8, bank0, pos2) from pos 0 → 2 forward steps, shift_en_o high 4 cycles, rvalid_o at cycle 6; then read 0x020 → no shift, rdata_o = 0xDEADBEEF; shift_total_o = 2.
- From bank0 pos 0, read 0x030 (w12, pos3) → d = 3, 1 backward step (shift_dir_o = 0), rvalid_o at cycle 4; then read 0x000 → 1 forward step.
- Write be = 4'b0101, wdata 0x11223344, over 0xAABBCCDD → read returns 0xAA22CC44; be = 0 write → word unchanged, rvalid_o still pulses.
- Address 0x400 with ADDR_WIDTH = 11 and DEPTH_WORDS = 256 → err_o = 1, rdata_o = 0, no shift_en_o, pos unchanged.
- Assert rst_i during the SHIFT of a write → no rvalid_o, word unchanged, all pos_q = 0; next request is planned from pos 0.
